// File: rtl/lzw_dict_ctrl.sv
// lzw_dict_ctrl: single-request dictionary lookup/insert sequencer for the
// LZW compressor. Probes the primary hash table, falls back to the conflict
// table on a collision, and allocates/inserts new codes on a miss.
// Optional statistics counters are enabled by defining LZW_DICT_STATS_EN.
module lzw_dict_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int HASH_WIDTH = 12,
    parameter int CODE_WIDTH = 12,
    parameter int FIRST_CODE = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_key,
    input  logic [HASH_WIDTH-1:0] req_hash,
    input  logic                  req_insert,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [CODE_WIDTH-1:0] rsp_code,
    output logic                  rsp_inserted,
    output logic                  rsp_dropped,
    input  logic                  dict_clear,
    output logic                  dict_full,
    output logic [HASH_WIDTH-1:0] ht_addr,
    output logic                  ht_rd_en,
    input  logic                  ht_rd_vld,
    input  logic [DATA_WIDTH-1:0] ht_rd_key,
    input  logic [CODE_WIDTH-1:0] ht_rd_code,
    output logic                  ht_we,
    output logic                  ht_wr_vld,
    output logic [DATA_WIDTH-1:0] ht_wr_key,
    output logic [CODE_WIDTH-1:0] ht_wr_code,
    output logic                  ct_cs,
    output logic                  ct_we,
    output logic [DATA_WIDTH-1:0] ct_data,
    output logic [HASH_WIDTH-1:0] ct_hash_in,
    output logic [CODE_WIDTH-1:0] ct_map_in,
    input  logic                  ct_match,
    input  logic [CODE_WIDTH-1:0] ct_hash_out,
    input  logic                  ct_full,
    output logic                  ct_clr,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_ct_hits,
    output logic [31:0]           stat_inserts,
    output logic [31:0]           stat_drops
);

    typedef enum logic [2:0] {
        CLEAR, IDLE, HT_RD, HT_CMP, CT_RD, CT_CMP, INSERT, RESP
    } state_t;

    // next_code carries one extra bit so that "all codes used" is representable
    localparam logic [CODE_WIDTH:0] FirstCodeW = FIRST_CODE[CODE_WIDTH:0];

    state_t                state_q;
    logic [HASH_WIDTH-1:0] clr_cnt_q;
    logic [CODE_WIDTH:0]   next_code_q;
    logic [CODE_WIDTH:0]   next_code_d;
    logic [DATA_WIDTH-1:0] key_q;
    logic [HASH_WIDTH-1:0] hash_q;
    logic                  ins_q;

    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_hit_q;
    logic [CODE_WIDTH-1:0] rsp_code_q;
    logic                  rsp_inserted_q;
    logic                  rsp_dropped_q;

    logic [HASH_WIDTH-1:0] ht_addr_q;
    logic                  ht_rd_en_q;
    logic                  ht_we_q;
    logic                  ht_wr_vld_q;
    logic [DATA_WIDTH-1:0] ht_wr_key_q;
    logic [CODE_WIDTH-1:0] ht_wr_code_q;
    logic                  ct_cs_q;
    logic                  ct_we_q;
    logic [DATA_WIDTH-1:0] ct_data_q;
    logic [HASH_WIDTH-1:0] ct_hash_in_q;
    logic [CODE_WIDTH-1:0] ct_map_in_q;
    logic                  ct_clr_q;

    logic                  full_w;

    assign full_w      = next_code_q[CODE_WIDTH];
    assign next_code_d = next_code_q + 1'b1;

    // Sequencer: every output is registered and set on the edge entering the state that owns it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CLEAR;
            clr_cnt_q      <= '0;
            next_code_q    <= FirstCodeW;
            key_q          <= '0;
            hash_q         <= '0;
            ins_q          <= 1'b0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_code_q     <= '0;
            rsp_inserted_q <= 1'b0;
            rsp_dropped_q  <= 1'b0;
            ht_addr_q      <= '0;
            ht_rd_en_q     <= 1'b0;
            ht_we_q        <= 1'b1;
            ht_wr_vld_q    <= 1'b0;
            ht_wr_key_q    <= '0;
            ht_wr_code_q   <= '0;
            ct_cs_q        <= 1'b0;
            ct_we_q        <= 1'b0;
            ct_data_q      <= '0;
            ct_hash_in_q   <= '0;
            ct_map_in_q    <= '0;
            ct_clr_q       <= 1'b1;
        end else begin
            ht_addr_q    <= '0;
            ht_rd_en_q   <= 1'b0;
            ht_we_q      <= 1'b0;
            ht_wr_vld_q  <= 1'b0;
            ht_wr_key_q  <= '0;
            ht_wr_code_q <= '0;
            ct_cs_q      <= 1'b0;
            ct_we_q      <= 1'b0;
            ct_data_q    <= '0;
            ct_hash_in_q <= '0;
            ct_map_in_q  <= '0;
            ct_clr_q     <= 1'b0;

            case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == '1) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                        ht_we_q   <= 1'b1;
                        ht_addr_q <= clr_cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (dict_clear) begin
                        state_q     <= CLEAR;
                        clr_cnt_q   <= '0;
                        next_code_q <= FirstCodeW;
                        req_ready_q <= 1'b0;
                        ht_we_q     <= 1'b1;
                        ct_clr_q    <= 1'b1;
                    end else if (req_valid) begin
                        state_q     <= HT_RD;
                        key_q       <= req_key;
                        hash_q      <= req_hash;
                        ins_q       <= req_insert;
                        req_ready_q <= 1'b0;
                        ht_rd_en_q  <= 1'b1;
                        ht_addr_q   <= req_hash;
                    end
                end
                HT_RD: begin
                    state_q <= HT_CMP;
                end
                HT_CMP: begin
                    if (!ht_rd_vld) begin
                        if (ins_q && !full_w) begin
                            state_q      <= INSERT;
                            ht_we_q      <= 1'b1;
                            ht_wr_vld_q  <= 1'b1;
                            ht_addr_q    <= hash_q;
                            ht_wr_key_q  <= key_q;
                            ht_wr_code_q <= next_code_q[CODE_WIDTH-1:0];
                        end else begin
                            state_q        <= RESP;
                            rsp_valid_q    <= 1'b1;
                            rsp_hit_q      <= 1'b0;
                            rsp_code_q     <= '0;
                            rsp_inserted_q <= 1'b0;
                            rsp_dropped_q  <= ins_q;
                        end
                    end else if (ht_rd_key == key_q) begin
                        state_q        <= RESP;
                        rsp_valid_q    <= 1'b1;
                        rsp_hit_q      <= 1'b1;
                        rsp_code_q     <= ht_rd_code;
                        rsp_inserted_q <= 1'b0;
                        rsp_dropped_q  <= 1'b0;
                    end else begin
                        state_q      <= CT_RD;
                        ct_cs_q      <= 1'b1;
                        ct_data_q    <= key_q;
                        ct_hash_in_q <= hash_q;
                    end
                end
                CT_RD: begin
                    state_q <= CT_CMP;
                end
                CT_CMP: begin
                    if (ct_match) begin
                        state_q        <= RESP;
                        rsp_valid_q    <= 1'b1;
                        rsp_hit_q      <= 1'b1;
                        rsp_code_q     <= ct_hash_out;
                        rsp_inserted_q <= 1'b0;
                        rsp_dropped_q  <= 1'b0;
                    end else if (ins_q && !full_w && !ct_full) begin
                        state_q      <= INSERT;
                        ct_cs_q      <= 1'b1;
                        ct_we_q      <= 1'b1;
                        ct_data_q    <= key_q;
                        ct_hash_in_q <= hash_q;
                        ct_map_in_q  <= next_code_q[CODE_WIDTH-1:0];
                    end else begin
                        state_q        <= RESP;
                        rsp_valid_q    <= 1'b1;
                        rsp_hit_q      <= 1'b0;
                        rsp_code_q     <= '0;
                        rsp_inserted_q <= 1'b0;
                        rsp_dropped_q  <= ins_q;
                    end
                end
                INSERT: begin
                    state_q        <= RESP;
                    next_code_q    <= next_code_d;
                    rsp_valid_q    <= 1'b1;
                    rsp_hit_q      <= 1'b0;
                    rsp_code_q     <= next_code_q[CODE_WIDTH-1:0];
                    rsp_inserted_q <= 1'b1;
                    rsp_dropped_q  <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q        <= IDLE;
                        req_ready_q    <= 1'b1;
                        rsp_valid_q    <= 1'b0;
                        rsp_hit_q      <= 1'b0;
                        rsp_code_q     <= '0;
                        rsp_inserted_q <= 1'b0;
                        rsp_dropped_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_code     = rsp_code_q;
    assign rsp_inserted = rsp_inserted_q;
    assign rsp_dropped  = rsp_dropped_q;
    assign dict_full    = full_w;
    assign ht_addr      = ht_addr_q;
    assign ht_rd_en     = ht_rd_en_q;
    assign ht_we        = ht_we_q;
    assign ht_wr_vld    = ht_wr_vld_q;
    assign ht_wr_key    = ht_wr_key_q;
    assign ht_wr_code   = ht_wr_code_q;
    assign ct_cs        = ct_cs_q;
    assign ct_we        = ct_we_q;
    assign ct_data      = ct_data_q;
    assign ct_hash_in   = ct_hash_in_q;
    assign ct_map_in    = ct_map_in_q;
    assign ct_clr       = ct_clr_q;

`ifdef LZW_DICT_STATS_EN
    logic [31:0] stat_hits_q;
    logic [31:0] stat_ct_hits_q;
    logic [31:0] stat_inserts_q;
    logic [31:0] stat_drops_q;
    logic        ct_path_hit_q;
    logic        stat_clr_w;
    logic        rsp_fire_w;

    assign stat_clr_w = (state_q == IDLE) && dict_clear;
    assign rsp_fire_w = rsp_valid_q && rsp_ready;

    // Remembers whether the pending hit came from the conflict table rather than the primary table
    always_ff @(posedge clk) begin
        if (rst) begin
            ct_path_hit_q <= 1'b0;
        end else if (state_q == CT_CMP) begin
            ct_path_hit_q <= ct_match;
        end else if (state_q == IDLE) begin
            ct_path_hit_q <= 1'b0;
        end
    end

    // Saturating outcome counters, bumped when the response is consumed
    always_ff @(posedge clk) begin
        if (rst || stat_clr_w) begin
            stat_hits_q    <= '0;
            stat_ct_hits_q <= '0;
            stat_inserts_q <= '0;
            stat_drops_q   <= '0;
        end else if (rsp_fire_w) begin
            if (rsp_hit_q && !ct_path_hit_q && (stat_hits_q != '1)) begin
                stat_hits_q <= stat_hits_q + 1'b1;
            end
            if (rsp_hit_q && ct_path_hit_q && (stat_ct_hits_q != '1)) begin
                stat_ct_hits_q <= stat_ct_hits_q + 1'b1;
            end
            if (rsp_inserted_q && (stat_inserts_q != '1)) begin
                stat_inserts_q <= stat_inserts_q + 1'b1;
            end
            if (rsp_dropped_q && (stat_drops_q != '1)) begin
                stat_drops_q <= stat_drops_q + 1'b1;
            end
        end
    end

    assign stat_hits    = stat_hits_q;
    assign stat_ct_hits = stat_ct_hits_q;
    assign stat_inserts = stat_inserts_q;
    assign stat_drops   = stat_drops_q;
`else
    assign stat_hits    = '0;
    assign stat_ct_hits = '0;
    assign stat_inserts = '0;
    assign stat_drops   = '0;
`endif

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// tb_lzw_dict_ctrl: directed self-checking bench for lzw_dict_ctrl.
// Provides a behavioural primary hash-table RAM with one-cycle read latency;
// conflict-table responses are driven directly per vector. Uses a 9-bit code
// width so the dictionary-full boundary is reachable quickly.
module tb_lzw_dict_ctrl;

    localparam int DW = 64;
    localparam int HW = 12;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [DW-1:0] reqKey = '0;
    logic [HW-1:0] reqHash = '0;
    logic          reqInsert = 1'b0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic          rspHit;
    logic [CW-1:0] rspCode;
    logic          rspInserted;
    logic          rspDropped;
    logic          dictClear = 1'b0;
    logic          dictFull;
    logic [HW-1:0] htAddr;
    logic          htRdEn;
    logic          htRdVld = 1'b0;
    logic [DW-1:0] htRdKey = '0;
    logic [CW-1:0] htRdCode = '0;
    logic          htWe;
    logic          htWrVld;
    logic [DW-1:0] htWrKey;
    logic [CW-1:0] htWrCode;
    logic          ctCs;
    logic          ctWe;
    logic [DW-1:0] ctData;
    logic [HW-1:0] ctHashIn;
    logic [CW-1:0] ctMapIn;
    logic          ctMatch = 1'b0;
    logic [CW-1:0] ctHashOut = '0;
    logic          ctFull = 1'b0;
    logic          ctClr;
    logic [31:0]   statHits;
    logic [31:0]   statCtHits;
    logic [31:0]   statInserts;
    logic [31:0]   statDrops;

    int compareCount = 0;
    int mismatchCount = 0;

    // Monitor state, only ever written by the monitor process
    int            ctWeCount = 0;
    int            insWriteCount = 0;
    int            rspValidCount = 0;
    logic [DW-1:0] lastCtData = '0;
    logic [CW-1:0] lastCtMap = '0;

    // Behavioural primary table
    logic          memVld  [4096];
    logic [DW-1:0] memKey  [4096];
    logic [CW-1:0] memCode [4096];

    lzw_dict_ctrl #(
        .DATA_WIDTH(DW), .HASH_WIDTH(HW), .CODE_WIDTH(CW), .FIRST_CODE(256)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_key(reqKey),
        .req_hash(reqHash), .req_insert(reqInsert),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_hit(rspHit),
        .rsp_code(rspCode), .rsp_inserted(rspInserted), .rsp_dropped(rspDropped),
        .dict_clear(dictClear), .dict_full(dictFull),
        .ht_addr(htAddr), .ht_rd_en(htRdEn), .ht_rd_vld(htRdVld),
        .ht_rd_key(htRdKey), .ht_rd_code(htRdCode),
        .ht_we(htWe), .ht_wr_vld(htWrVld), .ht_wr_key(htWrKey), .ht_wr_code(htWrCode),
        .ct_cs(ctCs), .ct_we(ctWe), .ct_data(ctData), .ct_hash_in(ctHashIn),
        .ct_map_in(ctMapIn), .ct_match(ctMatch), .ct_hash_out(ctHashOut),
        .ct_full(ctFull), .ct_clr(ctClr),
        .stat_hits(statHits), .stat_ct_hits(statCtHits),
        .stat_inserts(statInserts), .stat_drops(statDrops)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    // Primary table model: writes land on the edge, reads return one cycle later
    always @(posedge clk) begin
        if (htWe) begin
            memVld[htAddr]  <= htWrVld;
            memKey[htAddr]  <= htWrKey;
            memCode[htAddr] <= htWrCode;
        end
        if (htRdEn) begin
            htRdVld  <= memVld[htAddr];
            htRdKey  <= memKey[htAddr];
            htRdCode <= memCode[htAddr];
        end
    end

    // Counts table writes and responses so the stimulus can check deltas
    always @(posedge clk) begin
        if (ctWe) begin
            ctWeCount  <= ctWeCount + 1;
            lastCtData <= ctData;
            lastCtMap  <= ctMapIn;
        end
        if (htWe && htWrVld) insWriteCount <= insWriteCount + 1;
        if (rspValid) rspValidCount <= rspValidCount + 1;
    end

    // Guards against a hung sequencer
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Counts CLEAR cycles from the current negedge (first CLEAR cycle) until req_ready
    task automatic waitClear(input string tag);
        int n = 0;
        int bad = 0;
        int clrs = 0;
        while (!reqReady && n < 5000) begin
            if (!htWe || htWrVld || rspValid) bad++;
            if (ctClr) clrs++;
            n++;
            @(negedge clk);
        end
        checkOutput({tag, ".cycles"}, 64'(n), 64'd4096);
        checkOutput({tag, ".weEvery"}, 64'(bad), 64'd0);
        checkOutput({tag, ".ctClrOnce"}, 64'(clrs), 64'd1);
        checkOutput({tag, ".ready"}, 64'(reqReady), 64'd1);
        checkOutput({tag, ".notFull"}, 64'(dictFull), 64'd0);
    endtask

    // One request through to its response handshake, optionally stalling the response
    task automatic applyStimulus(input string tag, input logic [DW-1:0] key, input logic [HW-1:0] hash,
                                 input logic ins, input int hold, input int expLat, input logic expHit,
                                 input logic [CW-1:0] expCode, input logic expIns, input logic expDrop);
        int lat;
        @(negedge clk);
        checkOutput({tag, ".reqReady"}, 64'(reqReady), 64'd1);
        reqKey    = key;
        reqHash   = hash;
        reqInsert = ins;
        reqValid  = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 1;
        while (!rspValid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, ".hit"}, 64'(rspHit), 64'(expHit));
        checkOutput({tag, ".inserted"}, 64'(rspInserted), 64'(expIns));
        checkOutput({tag, ".dropped"}, 64'(rspDropped), 64'(expDrop));
        if (expHit || expIns) checkOutput({tag, ".code"}, 64'(rspCode), 64'(expCode));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".holdValid"}, 64'(rspValid), 64'd1);
            checkOutput({tag, ".holdHit"}, 64'(rspHit), 64'(expHit));
            checkOutput({tag, ".holdReqReady"}, 64'(reqReady), 64'd0);
        end
        rspReady = 1'b1;
        @(posedge clk);
        #1 rspReady = 1'b0;
        checkOutput({tag, ".rspDone"}, 64'(rspValid), 64'd0);
    endtask

    localparam logic [DW-1:0] K1 = 64'h1122334455667788;
    localparam logic [DW-1:0] K2 = 64'h8877665544332211;
    localparam logic [DW-1:0] K3 = 64'hDEADBEEF00000001;
    localparam logic [DW-1:0] K4 = 64'h0000CAFE0000F00D;

    initial begin
        int ctBase;
        int insBase;
        int rspBase;

        $display("[TB] start");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset.reqReady", 64'(reqReady), 64'd0);
        checkOutput("reset.rspValid", 64'(rspValid), 64'd0);
        checkOutput("reset.ctClr", 64'(ctClr), 64'd1);
        rst = 1'b0;
        waitClear("initClear");

        // Primary insert then primary hit
        applyStimulus("ins1", K1, 12'h123, 1'b1, 0, 4, 1'b0, 9'd256, 1'b1, 1'b0);
        applyStimulus("hit1", K1, 12'h123, 1'b0, 0, 3, 1'b1, 9'd256, 1'b0, 1'b0);

        // Collision goes to the conflict table
        ctBase = ctWeCount;
        applyStimulus("ctIns", K2, 12'h123, 1'b1, 0, 6, 1'b0, 9'd257, 1'b1, 1'b0);
        checkOutput("ctIns.weCount", 64'(ctWeCount - ctBase), 64'd1);
        checkOutput("ctIns.mapIn", 64'(lastCtMap), 64'd257);
        checkOutput("ctIns.data", lastCtData, K2);

        ctMatch = 1'b1;
        ctHashOut = 9'd257;
        applyStimulus("ctHit", K2, 12'h123, 1'b0, 0, 5, 1'b1, 9'd257, 1'b0, 1'b0);
        ctMatch = 1'b0;
        ctHashOut = '0;

        // Conflict table full: dropped, nothing written
        ctFull = 1'b1;
        ctBase = ctWeCount;
        applyStimulus("ctFull", K3, 12'h123, 1'b1, 0, 5, 1'b0, 9'd0, 1'b0, 1'b1);
        checkOutput("ctFull.weCount", 64'(ctWeCount - ctBase), 64'd0);
        ctFull = 1'b0;

        // Plain miss with a stalled response, then insert there (code proves next_code held)
        applyStimulus("miss", K4, 12'h200, 1'b0, 5, 3, 1'b0, 9'd0, 1'b0, 1'b0);
        applyStimulus("ins2", K4, 12'h200, 1'b1, 0, 4, 1'b0, 9'd258, 1'b1, 1'b0);

        // Fill the remaining codes 259..511
        for (int i = 0; i < 253; i++) begin
            applyStimulus("fill", {32'hA5A50000, 32'(i)}, 12'(12'h300 + i), 1'b1, 0, 4,
                          1'b0, 9'(259 + i), 1'b1, 1'b0);
        end
        checkOutput("full.flag", 64'(dictFull), 64'd1);
        insBase = insWriteCount;
        applyStimulus("full.drop", K3, 12'h500, 1'b1, 0, 3, 1'b0, 9'd0, 1'b0, 1'b1);
        checkOutput("full.noWrite", 64'(insWriteCount - insBase), 64'd0);
        checkOutput("full.sticky", 64'(dictFull), 64'd1);
        applyStimulus("full.hit", K1, 12'h123, 1'b0, 0, 3, 1'b1, 9'd256, 1'b0, 1'b0);

        // dict_clear wins over a simultaneous request
        rspBase = rspValidCount;
        @(negedge clk);
        dictClear = 1'b1;
        reqKey = K1;
        reqHash = 12'h123;
        reqInsert = 1'b1;
        reqValid = 1'b1;
        @(posedge clk);
        #1;
        dictClear = 1'b0;
        reqValid = 1'b0;
        checkOutput("clear.reqReady", 64'(reqReady), 64'd0);
        checkOutput("clear.ctClr", 64'(ctClr), 64'd1);
        checkOutput("clear.htAddr", 64'(htAddr), 64'd0);
        @(negedge clk);
        waitClear("dictClear");
        checkOutput("clear.noRsp", 64'(rspValidCount - rspBase), 64'd0);
        applyStimulus("postClear", K1, 12'h123, 1'b1, 0, 4, 1'b0, 9'd256, 1'b1, 1'b0);

        // Reset during CT_CMP aborts the collision insert
        ctBase = ctWeCount;
        insBase = insWriteCount;
        rspBase = rspValidCount;
        @(negedge clk);
        reqKey = K2;
        reqHash = 12'h123;
        reqInsert = 1'b1;
        reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort.ctCs", 64'(ctCs), 64'd1);
        checkOutput("abort.ctHash", 64'(ctHashIn), 64'h123);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitClear("abortClear");
        checkOutput("abort.noRsp", 64'(rspValidCount - rspBase), 64'd0);
        checkOutput("abort.noCtWe", 64'(ctWeCount - ctBase), 64'd0);
        checkOutput("abort.noInsWrite", 64'(insWriteCount - insBase), 64'd0);
        applyStimulus("abort.miss", K1, 12'h123, 1'b0, 0, 3, 1'b0, 9'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
